// File: rtl/instr_fetch_if.sv
// Bus bundle for instr_fetch: PC branch controls, program-memory fetch port and execute handshake.
interface instr_fetch_if #(
  parameter int unsigned Psize = 8,
  parameter int unsigned Isize = 16
) ();
  logic [Psize-1:0] PCout;
  logic             PCincr;
  logic             PCabsbranch;
  logic             PCrelbranch;
  logic [Psize-1:0] Branchaddr;
  logic             Imem_req;
  logic [Psize-1:0] Imem_addr;
  logic             Imem_ack;
  logic [Isize-1:0] Imem_data;
  logic             Instr_valid;
  logic [Isize-1:0] Instr;
  logic             Instr_ready;

  modport master (
    input  PCout, Imem_ack, Imem_data, Instr_ready,
    output PCincr, PCabsbranch, PCrelbranch, Branchaddr,
           Imem_req, Imem_addr, Instr_valid, Instr
  );

  modport slave (
    output PCout, Imem_ack, Imem_data, Instr_ready,
    input  PCincr, PCabsbranch, PCrelbranch, Branchaddr,
           Imem_req, Imem_addr, Instr_valid, Instr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch controller: fetches at PC, resolves JMP/BR/HALT locally, issues the rest to execute.
// Optional fetch watchdog (Fault) is built only when FETCH_TIMEOUT_EN is defined.
module instr_fetch #(
  parameter int unsigned Psize = 8,
  parameter int unsigned Isize = 16
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus,
  output logic          Halted,
  output logic          Fault
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] ISSUE  = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  localparam logic [3:0] OP_HALT = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BR   = 4'hF;

  logic [2:0]       state_q, state_d;
  logic [Isize-1:0] ir_q, ir_d;
  logic [Isize-1:0] instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             halted_q, halted_d;
  logic [3:0]       opcode;

  assign opcode = ir_q[Isize-1 -: 4];

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            fault_q, fault_d;
  logic            tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT - 1));

  // Counts ack-less REQ cycles; any other state leaves it cleared for the next fetch.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == REQ && !bus.Imem_ack) tmo_cnt_d = tmo_cnt_q + TmoW'(1);
  end
`endif

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    instr_d         = instr_q;
    instr_valid_d   = instr_valid_q;
    halted_d        = halted_q;
    bus.PCincr      = 1'b0;
    bus.PCabsbranch = 1'b0;
    bus.PCrelbranch = 1'b0;
    bus.Branchaddr  = '0;
    bus.Imem_req    = 1'b0;
    bus.Imem_addr   = '0;
`ifdef FETCH_TIMEOUT_EN
    fault_d         = fault_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        bus.Imem_req  = 1'b1;
        bus.Imem_addr = bus.PCout;
        if (bus.Imem_ack) begin
          ir_d    = bus.Imem_data;
          state_d = DECODE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d  = HALTED;
          halted_d = 1'b1;
          fault_d  = 1'b1;
        end
`endif
      end
      // PC controls are pulsed from IR so the PC has moved by the next REQ.
      DECODE: begin
        case (opcode)
          OP_JMP: begin
            bus.PCabsbranch = 1'b1;
            bus.Branchaddr  = ir_q[Psize-1:0];
            state_d         = REQ;
          end
          OP_BR: begin
            bus.PCrelbranch = 1'b1;
            bus.Branchaddr  = ir_q[Psize-1:0];
            state_d         = REQ;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end
          default: begin
            bus.PCincr    = 1'b1;
            instr_d       = ir_q;
            instr_valid_d = 1'b1;
            state_d       = ISSUE;
          end
        endcase
      end
      ISSUE: begin
        if (bus.Instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ir_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      fault_q   <= fault_d;
    end
  end

  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  assign bus.Instr_valid = instr_valid_q;
  assign bus.Instr       = instr_q;
  assign Halted          = halted_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing cases plus random programs scored against a program-level model.
module tb_instr_fetch;
  localparam int unsigned PW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned TMO = 15;
  localparam int unsigned K = 60;
  localparam int unsigned NITER = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Halted, Fault;

  instr_fetch_if #(.Psize(PW), .Isize(IW)) bus ();

  instr_fetch #(.Psize(PW), .Isize(IW)) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .Halted(Halted), .Fault(Fault)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Program counter the controller steers.
  logic [PW-1:0] pc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (bus.PCabsbranch) pc <= bus.Branchaddr;
    else if (bus.PCrelbranch) pc <= pc + bus.Branchaddr;
    else if (bus.PCincr) pc <= pc + PW'(1);
  end
  assign bus.PCout = pc;

  logic [IW-1:0] mem [256];
  int ack_mode = 0;     // 0 ack at once, 1 random, 2 never, 3 on REQ cycle TMO
  int ready_mode = 0;   // 0 always, 1 random, 2 never
  int ack_limit = 1000000;
  int acks_given = 0;
  int req_run = 0;

  // Memory and execute-side driver, updated just after each rising edge.
  initial begin
    logic ack;
    bus.Imem_ack = 1'b0;
    bus.Imem_data = '0;
    bus.Instr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        acks_given = 0;
        req_run = 0;
      end
      if (bus.Imem_req) req_run++;
      else req_run = 0;
      case (ack_mode)
        0: ack = bus.Imem_req;
        1: ack = bus.Imem_req ? ($urandom_range(1, 0) == 1 || req_run >= 8)
                              : ($urandom_range(3, 0) == 0);
        3: ack = bus.Imem_req && (req_run == TMO);
        default: ack = 1'b0;
      endcase
      if (bus.Imem_req && acks_given >= ack_limit) ack = 1'b0;
      if (bus.Imem_req && ack) acks_given++;
      bus.Imem_ack = ack;
      bus.Imem_data = bus.Imem_req ? mem[bus.Imem_addr] : IW'($urandom);
      case (ready_mode)
        0: bus.Instr_ready = 1'b1;
        1: bus.Instr_ready = ($urandom_range(1, 0) == 1);
        default: bus.Instr_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard queues filled by the program-level model.
  bit sb_en = 1'b0;
  logic [PW-1:0] exp_fetch[$];
  logic [IW-1:0] exp_issue[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && sb_en) begin
        if (bus.Imem_req && bus.Imem_ack) begin
          if (exp_fetch.size() == 0) begin
            n_total++;
            $display("FAIL fetch_extra: fetch at %0h, model expected none", bus.Imem_addr);
          end else check("fetch_addr", 64'(bus.Imem_addr), 64'(exp_fetch.pop_front()));
        end
        if (bus.Instr_valid && bus.Instr_ready) begin
          if (exp_issue.size() == 0) begin
            n_total++;
            $display("FAIL issue_extra: issued %0h, model expected none", bus.Instr);
          end else check("issue_instr", 64'(bus.Instr), 64'(exp_issue.pop_front()));
        end
      end
    end
  end

  // Always-on protocol properties.
  initial begin
    bit hold_valid;
    logic [IW-1:0] hold_instr;
    hold_valid = 1'b0;
    hold_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold_valid = 1'b0;
      else begin
        check("pc_ctrl_onehot",
              64'($countones({bus.PCincr, bus.PCabsbranch, bus.PCrelbranch}) <= 1), 64'(1));
        if (!(bus.PCabsbranch || bus.PCrelbranch))
          check("branchaddr_idle", 64'(bus.Branchaddr), 64'(0));
        if (Halted)
          check("halted_quiet", 64'({bus.Imem_req, bus.Instr_valid, bus.PCincr,
                                     bus.PCabsbranch, bus.PCrelbranch}), 64'(0));
        if (Fault) check("fault_implies_halt", 64'(Halted), 64'(1));
        if (hold_valid)
          check("issue_stable", 64'({bus.Instr_valid, bus.Instr}), 64'({1'b1, hold_instr}));
        hold_valid = bus.Instr_valid && !bus.Instr_ready;
        hold_instr = bus.Instr;
      end
    end
  end

  task automatic fill_mem(input logic [IW-1:0] v);
    for (int a = 0; a < 256; a++) mem[a] = v;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({bus.Imem_req, bus.Imem_addr, bus.PCincr, bus.PCabsbranch, bus.PCrelbranch,
               bus.Branchaddr, bus.Instr_valid, bus.Instr, Halted, Fault}), 64'(0));
    rst_n = 1'b1;
  endtask

  task automatic wait_fetch(input logic [PW-1:0] a);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.Imem_req && bus.Imem_addr == a) found = 1'b1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL wait_fetch: no request at %0h within 200 cycles", a);
    end
  endtask

  // Walks the program as an interpreter, recording fetch addresses and forwarded words.
  task automatic model_run(output bit halts);
    logic [PW-1:0] p;
    logic [IW-1:0] w;
    p = '0;
    halts = 1'b0;
    for (int k = 0; k < int'(K); k++) begin
      exp_fetch.push_back(p);
      w = mem[p];
      if (w[15:12] == 4'hC) begin
        halts = 1'b1;
        break;
      end
      if (w[15:12] == 4'hE) p = w[7:0];
      else if (w[15:12] == 4'hF) p = p + w[7:0];
      else begin
        exp_issue.push_back(w);
        p = p + PW'(1);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit exp_halt, done;
    logic [3:0] op;

    // Forwarded word with immediate ack and ready.
    fill_mem(16'h0000);
    mem[0] = 16'h1234;
    do_reset();
    @(negedge clk);
    check("t1_req", 64'({bus.Imem_req, bus.Imem_addr}), 64'({1'b1, 8'h00}));
    @(negedge clk);
    check("t1_decode", 64'({bus.PCincr, bus.Instr_valid}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    check("t1_issue", 64'({bus.Instr_valid, bus.Instr, bus.PCincr}), 64'({1'b1, 16'h1234, 1'b0}));
    @(negedge clk);
    check("t1_next_addr", 64'({bus.Imem_req, bus.Imem_addr}), 64'({1'b1, 8'h01}));

    // Absolute jump at PC 5.
    fill_mem(16'h0000);
    mem[5] = 16'hE040;
    do_reset();
    wait_fetch(8'h05);
    @(negedge clk);
    check("t2_jmp", 64'({bus.PCabsbranch, bus.PCrelbranch, bus.PCincr, bus.Branchaddr, bus.Instr_valid}),
          64'({1'b1, 1'b0, 1'b0, 8'h40, 1'b0}));
    @(negedge clk);
    check("t2_target", 64'({bus.Imem_req, bus.Imem_addr, bus.PCabsbranch, bus.Instr_valid}),
          64'({1'b1, 8'h40, 1'b0, 1'b0}));

    // Relative branches, backward and wrapping forward, ending in HALT.
    fill_mem(16'h0000);
    mem[8'h00] = 16'hE010;
    mem[8'h10] = 16'hF0FE;
    mem[8'h0E] = 16'hE0FE;
    mem[8'hFE] = 16'hF005;
    mem[8'h03] = 16'hC000;
    do_reset();
    wait_fetch(8'h10);
    @(negedge clk);
    check("t3_br_back", 64'({bus.PCrelbranch, bus.PCabsbranch, bus.Branchaddr}), 64'({1'b1, 1'b0, 8'hFE}));
    @(negedge clk);
    check("t3_back_addr", 64'({bus.Imem_req, bus.Imem_addr}), 64'({1'b1, 8'h0E}));
    wait_fetch(8'hFE);
    @(negedge clk);
    check("t3_br_wrap", 64'({bus.PCrelbranch, bus.Branchaddr}), 64'({1'b1, 8'h05}));
    @(negedge clk);
    check("t3_wrap_addr", 64'({bus.Imem_req, bus.Imem_addr}), 64'({1'b1, 8'h03}));
    @(negedge clk);
    check("t3_halt_decode", 64'({bus.PCincr, bus.PCabsbranch, bus.PCrelbranch, Halted}), 64'(0));
    @(negedge clk);
    check("t3_halted", 64'({Halted, bus.Imem_req}), 64'({1'b1, 1'b0}));

    // Execute stalls for several cycles; then reset lands during a stalled issue.
    fill_mem(16'h0000);
    mem[0] = 16'h1234;
    ready_mode = 2;
    do_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_stall", 64'({bus.Instr_valid, bus.Instr, bus.Imem_req}), 64'({1'b1, 16'h1234, 1'b0}));
    end
    ready_mode = 0;
    @(negedge clk);
    check("t4_stall_last", 64'({bus.Instr_valid, bus.Imem_req}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    check("t4_accepted", 64'({bus.Imem_req, bus.Imem_addr, bus.Instr_valid}), 64'({1'b1, 8'h01, 1'b0}));
    ready_mode = 2;
    repeat (2) @(negedge clk);
    check("t4_reissue", 64'(bus.Instr_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("t4_async_reset", 64'({bus.Instr_valid, bus.Instr, bus.Imem_req}), 64'(0));
    ready_mode = 0;

    // HALT is sticky until reset, then fetching restarts at 0.
    fill_mem(16'h0000);
    mem[2] = 16'hC000;
    do_reset();
    wait_fetch(8'h02);
    @(negedge clk);
    check("t5_decode", 64'(Halted), 64'(0));
    @(negedge clk);
    check("t5_halted", 64'({Halted, bus.Imem_req}), 64'({1'b1, 1'b0}));
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.Imem_req || !Halted) n++;
    end
    check("t5_sticky", 64'(n), 64'(0));
    do_reset();
    @(negedge clk);
    check("t5_resume", 64'({bus.Imem_req, bus.Imem_addr, Halted}), 64'({1'b1, 8'h00, 1'b0}));

`ifdef FETCH_TIMEOUT_EN
    // Watchdog expiry, then ack arriving on the limit cycle.
    ack_mode = 2;
    do_reset();
    n = 0;
    for (int i = 0; i < 40 && !Halted; i++) begin
      @(negedge clk);
      if (bus.Imem_req) n++;
    end
    check("t6_tmo_cycles", 64'(n), 64'(TMO));
    check("t6_tmo_flags", 64'({Fault, Halted, bus.Imem_req}), 64'({1'b1, 1'b1, 1'b0}));
    fill_mem(16'h1234);
    ack_mode = 3;
    ready_mode = 2;
    do_reset();
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.Imem_req) n++;
      else done = 1'b1;
    end
    check("t6_ack_cycles", 64'(n), 64'(TMO));
    check("t6_ack_wins", 64'({bus.PCincr, Fault, Halted}), 64'({1'b1, 1'b0, 1'b0}));
    ready_mode = 0;
`else
    ack_mode = 2;
    do_reset();
    repeat (40) @(negedge clk);
    check("t6_no_watchdog", 64'({bus.Imem_req, Fault, Halted}), 64'({1'b1, 1'b0, 1'b0}));
`endif

    // Random programs with random wait states and backpressure.
    for (int it = 0; it < int'(NITER); it++) begin
      for (int a = 0; a < 256; a++) begin
        n = int'($urandom_range(99, 0));
        if (n < 12) op = 4'hE;
        else if (n < 24) op = 4'hF;
        else if (n < 27) op = 4'hC;
        else begin
          op = 4'($urandom_range(12, 0));
          if (op == 4'hC) op = 4'hD;
        end
        mem[a] = {op, 12'($urandom)};
      end
      exp_fetch.delete();
      exp_issue.delete();
      model_run(exp_halt);
      ack_mode = 1;
      ready_mode = 1;
      ack_limit = K;
      do_reset();
      sb_en = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
        @(negedge clk);
        if (Halted || (acks_given >= int'(K) && bus.Imem_req && !bus.Imem_ack)) done = 1'b1;
      end
      if (!done) begin
        n_total++;
        $display("FAIL rand_budget: iteration %0d did not settle", it);
      end
      sb_en = 1'b0;
      check("rand_fetch_drained", 64'(exp_fetch.size()), 64'(0));
      check("rand_issue_drained", 64'(exp_issue.size()), 64'(0));
      check("rand_halt", 64'({Halted, Fault}), 64'({exp_halt, 1'b0}));
      ack_limit = 1000000;
    end

    ack_mode = 0;
    ready_mode = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch controller that sits between the program counter, program memory and the execute stage. Each instruction is fetched at the PC address via a req/ack handshake. Jumps, relative branches and halt are resolved locally by driving the PC's branch controls. Every other instruction goes to execute over a valid/ready handshake, and the PC is stepped by one.

## Interface
- Psize, 8: program address width; must match the PC.
- Isize, 16: instruction width; opcode is bits [Isize-1:Isize-4], operand is bits [Psize-1:0]; requires Isize-4 >= Psize.
- TIMEOUT, 15: fetch watchdog limit in cycles (used only with FETCH_TIMEOUT_EN).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCout  in  Psize  current PC value.
- PCincr  out  1  step PC by one.
- PCabsbranch  out  1  load Branchaddr into PC.
- PCrelbranch  out  1  add Branchaddr to PC.
- Branchaddr  out  Psize  branch target or offset.
- Imem_req  out  1  fetch request.
- Imem_addr  out  Psize  fetch address.
- Imem_ack  in  1  memory has Imem_data valid this cycle.
- Imem_data  in  Isize  fetched word.
- Instr_valid  out  1  Instr holds an instruction for execute.
- Instr  out  Isize  instruction to execute.
- Instr_ready  in  1  execute accepts Instr.
- Halted  out  1  HALT executed or fault; sticky until reset.
- Fault  out  1  fetch watchdog expired; sticky until reset; constant 0 without the macro.

## Operation
- Opcodes: 4'hE JMP (absolute), 4'hF BR (PC-relative), 4'hC HALT; all other opcodes are forwarded to execute.
- State IDLE:
  - Entered on reset.
  - Goes to REQ on the first clock edge after reset deasserts.
- State REQ:
  - Imem_req=1 and Imem_addr=PCout.
  - Held until an edge where Imem_ack=1; on that edge Imem_data is captured into the internal IR and the state goes to DECODE.
- State DECODE lasts exactly one cycle; PC controls are combinational from IR:
  - JMP: PCabsbranch=1, Branchaddr=IR[Psize-1:0], next state REQ.
  - BR: PCrelbranch=1, Branchaddr=IR[Psize-1:0], next state REQ.
    - PC add wraps modulo 2^Psize, so an offset of 8'hFF means -1.
  - HALT: next state HALTED; no PC control is asserted.
  - Other opcodes: PCincr=1, Instr<=IR, Instr_valid<=1, next state ISSUE.
- State ISSUE:
  - Instr_valid=1, and Instr is held stable until accepted.
  - On an edge with Instr_ready=1, Instr_valid<=0 and the state goes to REQ.
- State HALTED:
  - Halted=1; all handshake and PC control outputs are 0.
  - Only reset exits this state.
- At most one of PCincr, PCabsbranch or PCrelbranch is high in any cycle, and each is high only in DECODE.
- Branchaddr is 0 outside DECODE-branch cycles.

## Timing
- Reset values: state IDLE, IR=0, Instr=0, Instr_valid=0, Imem_req=0, Imem_addr=0, PCincr=PCabsbranch=PCrelbranch=0, Branchaddr=0, Halted=0, Fault=0.
- Reset asserted mid-operation takes effect immediately, even during ISSUE or while a fetch is outstanding.
- The PC updates on the DECODE edge, so the next REQ already presents the new PCout.
- Minimum instruction cost:
  - Forwarded instruction: 3 cycles (REQ, DECODE, ISSUE) with same-cycle ack and ready.
  - Branch or jump: 2 cycles.
- Imem_ack seen outside REQ is ignored. Instr_ready seen outside ISSUE is ignored.
- Memory wait states: each cycle REQ is held with Imem_ack=0 adds one cycle.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each REQ cycle with Imem_ack=0.
  - When the count reaches TIMEOUT without ack, the state goes to HALTED and Fault=1 and Halted=1 are set.
  - An ack arriving in the same cycle as the limit wins: the fetch completes normally.
- FETCH_TIMEOUT_EN undefined: no counter exists, REQ waits indefinitely, and Fault is tied to 0.

## Test plan
- Reset, then memory acks in the same cycle and returns 16'h1234 at PC 0, with Instr_ready=1 -> Instr=16'h1234 valid 3 cycles after leaving IDLE, one PCincr pulse, then Imem_addr=1.
- Word 16'hE040 at PC 5 -> single PCabsbranch with Branchaddr=8'h40; the next Imem_addr is 8'h40; no Instr_valid.
- Word 16'hF0FE at PC 8'h10 -> single PCrelbranch with Branchaddr=8'hFE; the next Imem_addr is 8'h0E. Also a wrap case: offset 8'h05 at PC 8'hFE -> next Imem_addr is 8'h03.
- Instr_ready held 0 for 4 cycles -> Instr stable and valid, and no Imem_req is issued until the acceptance edge.
- Word 16'hC000 -> Halted=1 the following cycle and no further Imem_req; assert reset -> Halted=0 and fetching resumes at Imem_addr=0.
- With FETCH_TIMEOUT_EN and TIMEOUT=15, Imem_ack never asserted -> Fault=1 and Halted=1 after 15 REQ cycles. Repeat with ack on exactly the 15th cycle -> normal DECODE and Fault=0.
